shift_reg_tx: RTL

Parallel-in, serial-out framed transmitter for the chapter-6 register library. It accepts a WIDTH-bit word through a load/ready handshake and holds it in an internal shift register. It then drives the word on a single serial line as start bit, data LSB-first, stop bit, with each bit held for CLKS_PER_BIT clocks. It is the sending end that feeds the parallel-load register path from a one-wire link.

---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_reg_tx_if.sv | 19 +
 rtl/shift_reg_tx_bit_timer.sv | 26 ++
 rtl/shift_reg_tx.sv | 76 +++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared state encoding, default parameters and width helpers
// for the framed serial transmitter.
package shift_reg_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_CLKS_PER_BIT = 2;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int DEF_TIMER_W = clog2_min1(DEF_CLKS_PER_BIT);
    localparam int DEF_INDEX_W = clog2_min1(DEF_WIDTH);

endpackage

// File: rtl/shift_reg_tx_if.sv
// shift_reg_tx_if: parallel load handshake and serial/status outputs of the
// transmitter; master drives the word, slave is the transmitter.
interface shift_reg_tx_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] I;
    logic             load;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (output I, load, input ready, sout, busy, done);
    modport slave  (input I, load, output ready, sout, busy, done);

endinterface

// File: rtl/shift_reg_tx_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 counter, cleared on clr, with a
// tick on the last count of each bit period.
module bit_timer
    import shift_reg_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int TW = clog2_min1(CLKS_PER_BIT);

    logic [TW-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == TW'(CLKS_PER_BIT - 1);
    assign cnt_d = (clr || tick) ? '0 : cnt_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shift_reg_tx.sv
// shift_reg_tx: parallel-in serial-out transmitter framing each word as
// start bit, LSB-first data, stop bit, each held CLKS_PER_BIT clocks.
module shift_reg_tx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input logic           clk,
    input logic           rst,
    shift_reg_tx_if.slave bus
);

    localparam int IW = clog2_min1(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             tick, accept, shift;

    assign accept = (state_q == IDLE) && bus.load;
    assign shift  = (state_q == DATA) && tick;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.load ? START : IDLE;
            START:   state_d = tick ? DATA : START;
            DATA:    state_d = (tick && idx_q == IW'(WIDTH - 1)) ? STOP : DATA;
            STOP:    state_d = tick ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // sout is registered from the next state so each bit appears the cycle its state begins
    always_comb begin
        shreg_d = accept ? bus.I : shift ? (shreg_q >> 1) : shreg_q;
        idx_d   = (accept || state_q == START) ? '0 : shift ? idx_q + IW'(1) : idx_q;
        sout_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
        done_d  = (state_q == STOP) && tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            sout_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = state_q == IDLE;
    assign bus.busy  = state_q != IDLE;
    assign bus.sout  = sout_q;
    assign bus.done  = done_q;

endmodule
